cnn_argmax_classifier: RTL and testbench

- Downstream stage of cnn_top: consumes the 10 signed class scores plus their one-cycle valid strobe.
- Runs a sequential argmax (one compare per cycle) and presents the predicted digit and its winning score on a valid/ready output.
- Feeds the result-reporting / LED / UART logic in the top-level design.

---
 rtl/cnn_argmax_classifier.sv | 128 ++++++++++++
 tb/tb_cnn_argmax_classifier.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/cnn_argmax_classifier.sv
// Sequential argmax over the cnn_top class scores with a valid/ready result port.
// Define ARGMAX_MARGIN_EN to add the best-minus-second-best margin output.
module cnn_argmax_classifier #(
  parameter int unsigned NUM_CLASSES = 10,
  parameter int unsigned ACC_W       = 32,
  parameter int unsigned CLASS_W     = $clog2(NUM_CLASSES)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic signed [ACC_W-1:0] class_scores [0:NUM_CLASSES-1],
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [CLASS_W-1:0]      pred_class,
  output logic signed [ACC_W-1:0] pred_score,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    overrun
`ifdef ARGMAX_MARGIN_EN
  ,
  output logic [ACC_W:0]          margin
`endif
);

  // Scan counter must be able to hold NUM_CLASSES, the "all compared" marker.
  localparam int unsigned CNT_W = $clog2(NUM_CLASSES + 1);
  localparam logic [CNT_W-1:0] SCAN_END = CNT_W'(NUM_CLASSES);

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DONE
  } state_t;

  state_t                  state;
  logic signed [ACC_W-1:0] bank [0:NUM_CLASSES-1];
  logic signed [ACC_W-1:0] best;
  logic [CLASS_W-1:0]      best_idx;
  logic [CNT_W-1:0]        scan_idx;
  logic signed [ACC_W-1:0] cur_c;
  logic                    take_c;

`ifdef ARGMAX_MARGIN_EN
  localparam logic signed [ACC_W-1:0] MIN_SCORE = {1'b1, {(ACC_W-1){1'b0}}};
  logic signed [ACC_W-1:0] second;
`endif

  // Current candidate and strict signed compare; ties keep the lower index.
  always_comb begin
    cur_c  = bank[CLASS_W'(scan_idx)];
    take_c = cur_c > best;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      in_ready   <= 1'b1;
      out_valid  <= 1'b0;
      pred_class <= '0;
      pred_score <= '0;
      overrun    <= 1'b0;
      best       <= '0;
      best_idx   <= '0;
      scan_idx   <= '0;
      for (int k = 0; k < int'(NUM_CLASSES); k++) begin
        bank[k] <= '0;
      end
`ifdef ARGMAX_MARGIN_EN
      second     <= '0;
      margin     <= '0;
`endif
    end else begin
      // in_ready is low exactly when the FSM is busy.
      overrun <= in_valid & ~in_ready;
      case (state)
        IDLE: begin
          if (in_valid) begin
            bank     <= class_scores;
            best     <= class_scores[0];
            best_idx <= '0;
            scan_idx <= CNT_W'(1);
`ifdef ARGMAX_MARGIN_EN
            second   <= MIN_SCORE;
`endif
            in_ready <= 1'b0;
            state    <= SCAN;
          end
        end
        SCAN: begin
          if (scan_idx == SCAN_END) begin
            pred_class <= best_idx;
            pred_score <= best;
            out_valid  <= 1'b1;
`ifdef ARGMAX_MARGIN_EN
            margin     <= {best[ACC_W-1], best} - {second[ACC_W-1], second};
`endif
            state      <= DONE;
          end else begin
            if (take_c) begin
              best     <= cur_c;
              best_idx <= CLASS_W'(scan_idx);
            end
`ifdef ARGMAX_MARGIN_EN
            if (take_c) begin
              second <= best;
            end else if (cur_c > second) begin
              second <= cur_c;
            end
`endif
            scan_idx <= scan_idx + CNT_W'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cnn_argmax_classifier.sv
// Scoreboard bench for cnn_argmax_classifier: reference argmax model, latency,
// backpressure, overrun, mid-scan reset and back-to-back vectors.
module tb_cnn_argmax_classifier;

  localparam int N = 10;

  typedef struct packed {
    logic [3:0]         cls;
    logic signed [31:0] score;
    logic [32:0]        margin;
  } exp_t;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               in_valid = 1'b0;
  logic               out_ready = 1'b1;
  logic signed [31:0] scores_tb [0:N-1];
  logic               in_ready;
  logic [3:0]         pred_class;
  logic signed [31:0] pred_score;
  logic               out_valid;
  logic               overrun;
`ifdef ARGMAX_MARGIN_EN
  logic [32:0]        margin;
`endif

  int   checks = 0;
  int   failures = 0;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  cnn_argmax_classifier dut (
    .clk         (clk),
    .rst         (rst),
    .class_scores(scores_tb),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .pred_class  (pred_class),
    .pred_score  (pred_score),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .overrun     (overrun)
`ifdef ARGMAX_MARGIN_EN
    ,
    .margin      (margin)
`endif
  );

  // Reference: first maximum wins; margin is max minus the best of the rest.
  function automatic exp_t model();
    exp_t   e;
    int     w = 0;
    longint sec = 0;
    bit     found = 0;
    for (int i = 1; i < N; i++) if (scores_tb[i] > scores_tb[w]) w = i;
    for (int i = 0; i < N; i++) begin
      if (i != w && (!found || longint'(scores_tb[i]) > sec)) begin
        sec = longint'(scores_tb[i]);
        found = 1;
      end
    end
    e.cls    = 4'(w);
    e.score  = scores_tb[w];
    e.margin = 33'(longint'(scores_tb[w]) - sec);
    return e;
  endfunction

  // Waits (bounded) for in_ready, pushes the expectation, pulses in_valid once.
  task automatic accept_vec();
    int guard = 0;
    while (!in_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL accept_timeout: in_ready=%b required 1", in_ready);
    end
    exp_q.push_back(model());
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Counts negedges after the accepting edge until out_valid (bounded at 50).
  task automatic await_out(output int lat);
    lat = 0;
    while (out_valid !== 1'b1 && lat < 50) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready: got %b required 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid: got %b required 0", out_valid); end
    checks++; if (pred_class !== 4'd0) begin failures++; $display("FAIL reset_pred_class: got %0d required 0", pred_class); end
    checks++; if (pred_score !== 32'sd0) begin failures++; $display("FAIL reset_pred_score: got %0d required 0", pred_score); end
    checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL reset_overrun: got %b required 0", overrun); end
`ifdef ARGMAX_MARGIN_EN
    checks++; if (margin !== 33'd0) begin failures++; $display("FAIL reset_margin: got %0d required 0", margin); end
`endif
  endtask

  // Ascending, negative/tie/most-negative, single max-positive patterns.
  task automatic test_patterns();
    exp_t e;
    int   lat;
    for (int p = 0; p < 3; p++) begin
      case (p)
        0: for (int i = 0; i < N; i++) scores_tb[i] = 32'(i);
        1: scores_tb = '{-5, -100, -3, 32'sh80000000, -4, -7, -9, -3, -50, -6};
        default: begin
          for (int i = 0; i < N; i++) scores_tb[i] = 32'sd0;
          scores_tb[0] = 32'sh7fffffff;
        end
      endcase
      accept_vec();
      for (int i = 0; i < N; i++) scores_tb[i] = 32'sd1000;
      await_out(lat);
      e = exp_q.pop_front();
      checks++; if (lat != 10) begin failures++; $display("FAIL pat%0d_latency: got %0d required 10", p, lat); end
      checks++; if (pred_class !== e.cls) begin failures++; $display("FAIL pat%0d_class: got %0d required %0d", p, pred_class, e.cls); end
      checks++; if (pred_score !== e.score) begin failures++; $display("FAIL pat%0d_score: got %0d required %0d", p, pred_score, e.score); end
      checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL pat%0d_ready_excl: in_ready=%b required 0", p, in_ready); end
`ifdef ARGMAX_MARGIN_EN
      checks++; if (margin !== e.margin) begin failures++; $display("FAIL pat%0d_margin: got %0d required %0d", p, margin, e.margin); end
`endif
      @(negedge clk);
      checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        failures++; $display("FAIL pat%0d_release: out_valid=%b in_ready=%b required 0/1", p, out_valid, in_ready);
      end
    end
  endtask

  task automatic test_backpressure();
    exp_t e;
    int   lat;
    int   bad = 0;
    int   ov_bad = 0;
    for (int i = 0; i < N; i++) scores_tb[i] = $signed($urandom());
    out_ready = 1'b0;
    accept_vec();
    await_out(lat);
    e = exp_q.pop_front();
    checks++; if (lat != 10) begin failures++; $display("FAIL bp_latency: got %0d required 10", lat); end
    for (int c = 0; c < 20; c++) begin
      in_valid = (c == 5);
      if (c == 5) for (int i = 0; i < N; i++) scores_tb[i] = 32'sh7fffffff;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || pred_class !== e.cls || pred_score !== e.score) bad++;
      if (overrun !== (c == 6)) ov_bad++;
      @(negedge clk);
    end
    in_valid = 1'b0;
    checks++; if (bad != 0) begin failures++; $display("FAIL bp_hold: %0d unstable cycles, required 0", bad); end
    checks++; if (ov_bad != 0) begin failures++; $display("FAIL bp_overrun: %0d wrong overrun cycles, required 0", ov_bad); end
    checks++; if (pred_class !== e.cls || pred_score !== e.score) begin
      failures++; $display("FAIL bp_result_after_overrun: got %0d/%0d required %0d/%0d", pred_class, pred_score, e.cls, e.score);
    end
    out_ready = 1'b1;
    @(negedge clk);
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++; $display("FAIL bp_release: out_valid=%b in_ready=%b required 0/1", out_valid, in_ready);
    end
    checks++; if (pred_score !== e.score) begin failures++; $display("FAIL bp_score_kept: got %0d required %0d", pred_score, e.score); end
  endtask

  task automatic test_reset_mid_scan();
    exp_t e;
    int   lat;
    int   stale = 0;
    for (int i = 0; i < N; i++) scores_tb[i] = 32'sd500 + 32'(i);
    accept_vec();
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || pred_class !== 4'd0) begin
      failures++; $display("FAIL midrst_state: in_ready=%b out_valid=%b class=%0d required 1/0/0", in_ready, out_valid, pred_class);
    end
    repeat (15) begin
      @(negedge clk);
      if (out_valid !== 1'b0) stale++;
    end
    checks++; if (stale != 0) begin failures++; $display("FAIL midrst_stale: %0d cycles with out_valid, required 0", stale); end
    for (int i = 0; i < N; i++) scores_tb[i] = 32'(9 - i);
    accept_vec();
    await_out(lat);
    e = exp_q.pop_front();
    checks++; if (lat != 10) begin failures++; $display("FAIL midrst_latency: got %0d required 10", lat); end
    checks++; if (pred_class !== e.cls) begin failures++; $display("FAIL midrst_class: got %0d required %0d", pred_class, e.cls); end
    checks++; if (pred_score !== e.score) begin failures++; $display("FAIL midrst_score: got %0d required %0d", pred_score, e.score); end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    exp_t e;
    int   lat;
    for (int v = 0; v < 2; v++) begin
      for (int i = 0; i < N; i++) scores_tb[i] = 32'($urandom_range(0, 7)) - 32'sd4;
      if (v == 1) begin
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL b2b_ready_return: got %b required 1", in_ready); end
      end
      accept_vec();
      await_out(lat);
      e = exp_q.pop_front();
      checks++; if (lat != 10) begin failures++; $display("FAIL b2b%0d_latency: got %0d required 10", v, lat); end
      checks++; if (pred_class !== e.cls) begin failures++; $display("FAIL b2b%0d_class: got %0d required %0d", v, pred_class, e.cls); end
      checks++; if (pred_score !== e.score) begin failures++; $display("FAIL b2b%0d_score: got %0d required %0d", v, pred_score, e.score); end
`ifdef ARGMAX_MARGIN_EN
      checks++; if (margin !== e.margin) begin failures++; $display("FAIL b2b%0d_margin: got %0d required %0d", v, margin, e.margin); end
`endif
      @(negedge clk);
    end
  endtask

  initial begin
    for (int i = 0; i < N; i++) scores_tb[i] = 32'sd0;
    @(negedge clk);
    test_reset();
    test_patterns();
    test_backpressure();
    test_reset_mid_scan();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
